// File: rtl/seven_seg_pkg.sv
// rtl/seven_seg_pkg.sv - shared segment encodings for the seven-segment scanner
package seven_seg_pkg;

  // Segment pattern that turns every segment off
  localparam logic [6:0] SEG_BLANK = 7'h00;

  // Hex digit to {g,f,e,d,c,b,a}; index 15 is the leftmost element
  localparam logic [15:0][6:0] HEX_SEG_TABLE = {
    7'h71, 7'h79, 7'h5E, 7'h39, 7'h7C, 7'h77, 7'h6F, 7'h7F,
    7'h07, 7'h7D, 7'h6D, 7'h66, 7'h4F, 7'h5B, 7'h06, 7'h3F
  };

endpackage

// File: rtl/hex_to_seg.sv
// rtl/hex_to_seg.sv - combinational hex nibble to seven-segment decoder
module hex_to_seg
  import seven_seg_pkg::*;
(
  input  logic [3:0] nibble,
  output logic [6:0] seg
);

  // Straight table lookup, no state
  always_comb begin
    seg = HEX_SEG_TABLE[nibble];
  end

endmodule

// File: rtl/seven_seg_scan.sv
// rtl/seven_seg_scan.sv - multiplexed hex display scanner with frame snapshot, blanking and PWM
module seven_seg_scan
  import seven_seg_pkg::*;
#(
  parameter int Digits     = 4,
  parameter int DivBits    = 16,
  parameter int BrightBits = 3
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [4*Digits-1:0]   data,
  input  logic [Digits-1:0]     dp,
  input  logic                  blank_lz,
  input  logic [BrightBits-1:0] bright,
  output logic [Digits-1:0]     an,
  output logic [6:0]            seg,
  output logic                  seg_dp,
  output logic                  frame_start
);

  localparam int IdxW = (Digits > 1) ? $clog2(Digits) : 1;
  localparam logic [IdxW-1:0] LastIdx = IdxW'(Digits - 1);
  localparam logic [DivBits-1:0] PMax = '1;

  logic [DivBits-1:0]    p_q, p_d;
  logic [IdxW-1:0]       idx_q, idx_d;
  logic [4*Digits-1:0]   data_sh_q, data_sh_d;
  logic [Digits-1:0]     dp_sh_q, dp_sh_d;
  logic                  blz_sh_q, blz_sh_d;
  logic [BrightBits-1:0] bright_sh_q, bright_sh_d;
  logic [Digits-1:0]     an_q, an_d;
  logic [6:0]            seg_q, seg_d;
  logic                  seg_dp_q, seg_dp_d;
  logic                  frame_start_q, frame_start_d;

  logic                  slot_end;
  logic                  frame_end;
  logic [Digits-1:0]     blank_mask;
  logic                  zero_above;
  logic [3:0]            cur_nib;
  logic                  cur_dp;
  logic                  cur_blank;
  logic                  lit;
  logic [6:0]            seg_raw;

  // Prescaler/digit counters and the once-per-frame input snapshot
  always_comb begin
    p_d           = p_q + DivBits'(1);
    slot_end      = (p_q == PMax);
    frame_end     = slot_end && (idx_q == LastIdx);
    idx_d         = idx_q;
    if (slot_end) begin
      idx_d = (idx_q == LastIdx) ? '0 : idx_q + IdxW'(1);
    end
    data_sh_d     = frame_end ? data     : data_sh_q;
    dp_sh_d       = frame_end ? dp       : dp_sh_q;
    blz_sh_d      = frame_end ? blank_lz : blz_sh_q;
    bright_sh_d   = frame_end ? bright   : bright_sh_q;
    frame_start_d = frame_end;
  end

  // Leading-zero mask from the top digit down, and per-digit selection on the current index
  always_comb begin
    blank_mask = '0;
    zero_above = 1'b1;
    for (int k = Digits - 1; k >= 0; k--) begin
      zero_above    = zero_above && (data_sh_q[4*k +: 4] == 4'h0);
      blank_mask[k] = (k != 0) && blz_sh_q && zero_above;
    end
    cur_nib   = 4'h0;
    cur_dp    = 1'b0;
    cur_blank = 1'b0;
    for (int k = 0; k < Digits; k++) begin
      if (idx_q == IdxW'(k)) begin
        cur_nib   = data_sh_q[4*k +: 4];
        cur_dp    = dp_sh_q[k];
        cur_blank = blank_mask[k];
      end
    end
  end

  hex_to_seg u_hex_to_seg (
    .nibble (cur_nib),
    .seg    (seg_raw)
  );

  // Next display outputs; the anode is gated by the PWM compare, segments hold for the slot
  always_comb begin
    lit      = (p_q[DivBits-1 -: BrightBits] <= bright_sh_q);
    an_d     = '0;
    if (!cur_blank && lit) begin
      an_d = Digits'(1) << idx_q;
    end
    seg_d    = cur_blank ? SEG_BLANK : seg_raw;
    seg_dp_d = !cur_blank && cur_dp;
  end

  // State register; reset parks the scan at end of frame so the first edge loads a snapshot
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      p_q           <= PMax;
      idx_q         <= LastIdx;
      data_sh_q     <= '0;
      dp_sh_q       <= '0;
      blz_sh_q      <= 1'b0;
      bright_sh_q   <= '0;
      an_q          <= '0;
      seg_q         <= SEG_BLANK;
      seg_dp_q      <= 1'b0;
      frame_start_q <= 1'b0;
    end else begin
      p_q           <= p_d;
      idx_q         <= idx_d;
      data_sh_q     <= data_sh_d;
      dp_sh_q       <= dp_sh_d;
      blz_sh_q      <= blz_sh_d;
      bright_sh_q   <= bright_sh_d;
      an_q          <= an_d;
      seg_q         <= seg_d;
      seg_dp_q      <= seg_dp_d;
      frame_start_q <= frame_start_d;
    end
  end

  assign an          = an_q;
  assign seg         = seg_q;
  assign seg_dp      = seg_dp_q;
  assign frame_start = frame_start_q;

endmodule
